// File: rtl/uart_word_tx.sv
// uart_word_tx
// Serializes one TAM_DATA-bit word from the debug unit into NUM_BYTES UART
// bytes, least-significant byte first. Each byte gets one start pulse to the
// UART transmitter. The next byte goes out after the transmitter's done tick
// for the current one. After the last byte completes, a single-cycle
// word-done pulse is issued.
//
// TAM_DATA must be a multiple of TAM_BYTE.
//
// Ports:
//   i_clk               system clock
//   i_reset_n           asynchronous active-low reset
//   i_start             word request, sampled only when idle
//   i_data              word captured when i_start is accepted
//   i_tx_done_tick      UART TX end-of-byte pulse
//   o_tx_start          single-cycle "send o_tx_byte" pulse to UART TX
//   o_tx_byte           byte presented to UART TX
//   o_tx_done_32b_word  single-cycle pulse after the last byte completes
//   o_busy              high whenever a word is in progress (not idle)
module uart_word_tx #(
    parameter int TAM_DATA  = 32,
    parameter int TAM_BYTE  = 8,
    parameter int NUM_BYTES = TAM_DATA / TAM_BYTE
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_start,
    input  logic [TAM_DATA-1:0] i_data,
    input  logic                i_tx_done_tick,
    output logic                o_tx_start,
    output logic [TAM_BYTE-1:0] o_tx_byte,
    output logic                o_tx_done_32b_word,
    output logic                o_busy
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3
    } state_t;

    state_t              state;
    logic [TAM_DATA-1:0] word_reg;
    logic [IDX_W-1:0]    byte_idx;
    logic [IDX_W-1:0]    next_idx;

    assign next_idx = byte_idx + 1'b1;

    // Outputs are registered. Each one is loaded with the value it must
    // carry in the state being entered, so the pulses line up with SEND
    // and DONE, and no input reaches an output combinationally.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state              <= ST_IDLE;
            word_reg           <= '0;
            byte_idx           <= '0;
            o_tx_start         <= 1'b0;
            o_tx_byte          <= '0;
            o_tx_done_32b_word <= 1'b0;
            o_busy             <= 1'b0;
        end else begin
            o_tx_start         <= 1'b0;
            o_tx_done_32b_word <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        word_reg   <= i_data;
                        byte_idx   <= '0;
                        o_tx_byte  <= i_data[TAM_BYTE-1:0];
                        o_tx_start <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done_tick) begin
                        if (byte_idx == LAST_IDX) begin
                            o_tx_done_32b_word <= 1'b1;
                            state              <= ST_DONE;
                        end else begin
                            byte_idx   <= next_idx;
                            o_tx_byte  <= word_reg[int'(next_idx) * TAM_BYTE +: TAM_BYTE];
                            o_tx_start <= 1'b1;
                            state      <= ST_SEND;
                        end
                    end
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    o_busy    <= 1'b0;
                    o_tx_byte <= '0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_tx_done_tick;
    logic        o_tx_start;
    logic [7:0]  o_tx_byte;
    logic        o_tx_done_32b_word;
    logic        o_busy;

    logic model_tick = 1'b0;
    logic stray_tick = 1'b0;
    assign i_tx_done_tick = model_tick | stray_tick;

    uart_word_tx #(.TAM_DATA(32), .TAM_BYTE(8)) dut (
        .i_clk              (i_clk),
        .i_reset_n          (i_reset_n),
        .i_start            (i_start),
        .i_data             (i_data),
        .i_tx_done_tick     (i_tx_done_tick),
        .o_tx_start         (o_tx_start),
        .o_tx_byte          (o_tx_byte),
        .o_tx_done_32b_word (o_tx_done_32b_word),
        .o_busy             (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: bytes still owed on the wire, and word-done pulses owed.
    logic [7:0] exp_bytes[$];
    int         exp_done = 0;
    logic [7:0] cur_byte = '0;

    // 0 selects a random delay of 1..6 cycles per byte.
    int tick_delay = 5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word is sent as its bytes in little-endian order, then one done pulse.
    function automatic void expect_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_bytes.push_back(w[8*b +: 8]);
        exp_done++;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a byte or a done pulse.
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_tx_start) begin
                check("done_during_start", 32'(o_tx_done_32b_word), 32'd0);
                check("start_with_pending_byte", 32'(o_tx_start), 32'(exp_bytes.size() != 0));
                if (exp_bytes.size() != 0) begin
                    cur_byte = exp_bytes.pop_front();
                    check("tx_byte", 32'(o_tx_byte), 32'(cur_byte));
                end
                check("busy_in_send", 32'(o_busy), 32'd1);
            end else if (o_tx_done_32b_word) begin
                check("done_with_pending_word", 32'(o_tx_done_32b_word), 32'(exp_done != 0));
                check("bytes_left_at_done", 32'(exp_bytes.size()), 32'd0);
                check("busy_in_done", 32'(o_busy), 32'd1);
                if (exp_done != 0) exp_done--;
            end else if (o_busy) begin
                check("tx_byte_hold", 32'(o_tx_byte), 32'(cur_byte));
            end
        end
    end

    // UART TX model: ticks a configurable number of cycles after each start,
    // and checks that the DUT reacts to every tick on the following cycle.
    int cnt = 0;
    bit ticked = 1'b0;
    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            cnt        = 0;
            model_tick = 1'b0;
            ticked     = 1'b0;
        end else begin
            if (ticked) check("tick_response", 32'(o_tx_start | o_tx_done_32b_word), 32'd1);
            ticked     = 1'b0;
            model_tick = 1'b0;
            if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    model_tick = 1'b1;
                    ticked     = 1'b1;
                end
            end
            if (o_tx_start) cnt = (tick_delay == 0) ? int'($urandom_range(1, 6)) : tick_delay;
        end
    end

    // Called at a negedge while the DUT is idle; returns at the SEND negedge.
    task automatic send_word(input logic [31:0] w);
        i_data     = w;
        i_start    = 1'b1;
        stray_tick = 1'b0;
        expect_word(w);
        @(negedge i_clk);
        i_start = 1'b0;
        i_data  = $urandom;
        check("start_latency", 32'(o_tx_start), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge i_clk);
            seen = o_tx_done_32b_word;
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_starts(input int n, input int budget);
        int c = 0;
        for (int k = 0; k < budget && c < n; k++) begin
            @(negedge i_clk);
            if (o_tx_start) c++;
        end
        check("starts_seen", 32'(c), 32'(n));
    endtask

    task automatic finish_word(input string name);
        wait_done(200);
        @(negedge i_clk);
        check(name, 32'(o_busy), 32'd0);
    endtask

    initial begin
        int bad;
        int gaps;
        repeat (3) @(negedge i_clk);
        check("rst_tx_start", 32'(o_tx_start), 32'd0);
        check("rst_tx_byte", 32'(o_tx_byte), 32'd0);
        check("rst_done", 32'(o_tx_done_32b_word), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        tick_delay = 5;
        send_word(32'hDEADBEEF);
        finish_word("busy_after_deadbeef");

        send_word(32'h00000001);
        finish_word("busy_idle_b2b");
        send_word(32'h80000000);
        finish_word("busy_after_b2b");

        send_word(32'h12345678);
        wait_starts(1, 100);
        @(negedge i_clk);
        i_data  = 32'hFFFFFFFF;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(200);
        i_data  = 32'hFFFFFFFF;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("busy_after_drop", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        check("drop_no_start", 32'(o_tx_start), 32'd0);
        check("drop_still_idle", 32'(o_busy), 32'd0);

        stray_tick = 1'b1;
        @(negedge i_clk);
        stray_tick = 1'b0;
        check("stray_idle_start", 32'(o_tx_start), 32'd0);
        check("stray_idle_busy", 32'(o_busy), 32'd0);
        check("stray_idle_done", 32'(o_tx_done_32b_word), 32'd0);
        tick_delay = 3;
        send_word(32'h0F1E2D3C);
        stray_tick = 1'b1;
        @(negedge i_clk);
        stray_tick = 1'b0;
        check("stray_send_start", 32'(o_tx_start), 32'd0);
        check("stray_send_busy", 32'(o_busy), 32'd1);
        finish_word("busy_after_stray");

        tick_delay = 5;
        send_word(32'hCAFEBABE);
        wait_starts(2, 100);
        @(negedge i_clk);
        #2 i_reset_n = 1'b0;
        #1;
        check("async_rst_start", 32'(o_tx_start), 32'd0);
        check("async_rst_byte", 32'(o_tx_byte), 32'd0);
        check("async_rst_done", 32'(o_tx_done_32b_word), 32'd0);
        check("async_rst_busy", 32'(o_busy), 32'd0);
        exp_bytes.delete();
        exp_done = 0;
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (5) @(negedge i_clk);
        check("idle_after_rst", 32'(o_busy), 32'd0);
        send_word(32'h0000A5A5);
        finish_word("busy_after_a5a5");

        tick_delay = 1000;
        send_word($urandom);
        repeat (10) @(negedge i_clk);
        tick_delay = 2;
        bad = 0;
        for (int k = 0; k < 980; k++) begin
            @(negedge i_clk);
            if (!(o_busy && !o_tx_start && !o_tx_done_32b_word)) bad++;
        end
        check("hold_in_wait", 32'(bad), 32'd0);
        finish_word("busy_after_hold");

        for (int w = 0; w < 30; w++) begin
            tick_delay = 0;
            send_word($urandom);
            finish_word("busy_after_random");
            gaps = int'($urandom_range(0, 3));
            for (int g = 0; g < gaps; g++) begin
                stray_tick = 1'($urandom_range(0, 1));
                @(negedge i_clk);
            end
            stray_tick = 1'b0;
        end

        repeat (5) @(negedge i_clk);
        check("leftover_bytes", 32'(exp_bytes.size()), 32'd0);
        check("leftover_done", 32'(exp_done), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
